rb_event_fifo: RTL and testbench

- Buffering stage between the readback arbiter output and the Jetson SPI link write side; absorbs bursts of 32-bit readback words ({addr[3:0], data[27:0]}).
- Supplies backpressure (in_rdy) to the arbiter and paces strobes toward the SPI link.
- Counts words dropped when upstream ignores backpressure, then reports them in-band as a marker word.

---
 rtl/rb_event_fifo.sv | 93 +++++++++
 tb/tb_rb_event_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rb_event_fifo.sv
// Readback event FIFO between the arbiter and the SPI link write side.
// Applies backpressure, paces output strobes and reports dropped words in-band as a marker word.
module rb_event_fifo #(
  parameter int          DEPTH     = 16,
  parameter int          GAP       = 0,
  parameter logic [3:0]  MARK_ADDR = 4'h8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_wr,
  input  logic [31:0]              in_data,
  output logic                     in_rdy,
  output logic                     out_wr,
  output logic [31:0]              out_data,
  input  logic                     out_rdy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop_pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GAP + 2);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [7:0]    drop_cnt;
  logic [GW-1:0] gap_cnt;

  logic        full, push, drop, marker, pop, wr_en;
  logic [31:0] wr_word;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign full         = (level == LW'(DEPTH));
  assign in_rdy       = !full && (drop_cnt == 8'd0);
  assign drop_pending = (drop_cnt != 8'd0);
  assign push         = in_wr && in_rdy;
  assign drop         = in_wr && !in_rdy;
  // Marker and push are mutually exclusive: a pending drop count holds in_rdy low.
  assign marker       = (drop_cnt != 8'd0) && !full;
  assign pop          = (level != '0) && out_rdy && (gap_cnt == '0);
  assign wr_en        = push || marker;
  assign wr_word      = marker ? {MARK_ADDR, 20'h0, drop_cnt} : in_data;

  // Storage array carries no reset; only pointers and counters are cleared.
  always_ff @(posedge clk) begin
    if (!flush && wr_en)
      mem[wptr] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      drop_cnt <= 8'd0;
      gap_cnt  <= '0;
      out_wr   <= 1'b0;
      out_data <= 32'd0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      drop_cnt <= 8'd0;
      gap_cnt  <= '0;
      out_wr   <= 1'b0;
    end else begin
      out_wr <= pop;
      if (wr_en)
        wptr <= wptr + AW'(1);
      if (pop) begin
        rptr     <= rptr + AW'(1);
        out_data <= mem[rptr];
        gap_cnt  <= GW'(GAP);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
      case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (marker)
        drop_cnt <= drop ? 8'd1 : 8'd0;
      else if (drop)
        drop_cnt <= sat_inc(drop_cnt);
    end
  end

endmodule

// File: tb/tb_rb_event_fifo.sv
// Directed bench for rb_event_fifo: ordering, backpressure, drop markers, pacing, flush and async reset.
module tb_rb_event_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0, in_wr = 1'b0, out_rdy = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_rdy, out_wr, drop_pending;
  logic [31:0] out_data;
  logic [4:0]  level;

  logic        g_flush = 1'b0, g_in_wr = 1'b0, g_out_rdy = 1'b0;
  logic [31:0] g_in_data = 32'd0;
  logic        g_in_rdy, g_out_wr, g_drop_pending;
  logic [31:0] g_out_data;
  logic [4:0]  g_level;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rb_event_fifo #(.DEPTH(16), .GAP(0), .MARK_ADDR(4'h8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_wr(in_wr), .in_data(in_data),
    .in_rdy(in_rdy), .out_wr(out_wr), .out_data(out_data), .out_rdy(out_rdy),
    .level(level), .drop_pending(drop_pending));

  rb_event_fifo #(.DEPTH(16), .GAP(3), .MARK_ADDR(4'h8)) dut_g (
    .clk(clk), .rst_n(rst_n), .flush(g_flush), .in_wr(g_in_wr), .in_data(g_in_data),
    .in_rdy(g_in_rdy), .out_wr(g_out_wr), .out_data(g_out_data), .out_rdy(g_out_rdy),
    .level(g_level), .drop_pending(g_drop_pending));

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++; if (out_wr !== 1'b0) begin fails++; $display("FAIL rst_out_wr got %b exp 0", out_wr); end
    tests++; if (out_data !== 32'd0) begin fails++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    tests++; if (level !== 5'd0) begin fails++; $display("FAIL rst_level got %0d exp 0", level); end
    tests++; if (drop_pending !== 1'b0) begin fails++; $display("FAIL rst_drop_pending got %b exp 0", drop_pending); end
    tests++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL rst_in_rdy got %b exp 1", in_rdy); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    out_rdy = 1'b1; in_wr = 1'b1; in_data = 32'h1000_0001;
    @(negedge clk);
    tests++; if (level !== 5'd1 || out_wr !== 1'b0) begin fails++; $display("FAIL basic_c1 got level=%0d out_wr=%b exp 1/0", level, out_wr); end
    in_data = 32'h2000_0002;
    @(negedge clk);
    in_wr = 1'b0;
    tests++; if (out_wr !== 1'b1 || out_data !== 32'h1000_0001) begin fails++; $display("FAIL basic_w0 got %b/%h exp 1/10000001", out_wr, out_data); end
    tests++; if (level !== 5'd1) begin fails++; $display("FAIL basic_level_pp got %0d exp 1", level); end
    @(negedge clk);
    tests++; if (out_wr !== 1'b1 || out_data !== 32'h2000_0002) begin fails++; $display("FAIL basic_w1 got %b/%h exp 1/20000002", out_wr, out_data); end
    @(negedge clk);
    tests++; if (out_wr !== 1'b0 || out_data !== 32'h2000_0002 || level !== 5'd0) begin
      fails++; $display("FAIL basic_idle got %b/%h/%0d exp 0/20000002/0", out_wr, out_data, level); end
  endtask

  task automatic fill_and_drop(input int ndrops);
    out_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_wr = 1'b1; in_data = 32'h1000_0000 | i;
      @(negedge clk);
    end
    tests++; if (level !== 5'd16 || in_rdy !== 1'b0) begin fails++; $display("FAIL full_state got level=%0d in_rdy=%b exp 16/0", level, in_rdy); end
    for (int k = 0; k < ndrops; k++) begin
      in_data = 32'hDEAD_0000 | k;
      @(negedge clk);
    end
    in_wr = 1'b0;
    tests++; if (drop_pending !== 1'b1 || level !== 5'd16) begin fails++; $display("FAIL drop_pending got %b level=%0d exp 1/16", drop_pending, level); end
  endtask

  task automatic drain_check(input logic [31:0] mark);
    int n = 0;
    logic [31:0] exp;
    out_rdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_wr) begin
        exp = (n < 16) ? (32'h1000_0000 | n) : mark;
        if (n < 17) begin
          tests++; if (out_data !== exp) begin fails++; $display("FAIL drain_word%0d got %h exp %h", n, out_data, exp); end
        end
        n++;
      end
    end
    tests++; if (n != 17) begin fails++; $display("FAIL drain_count got %0d exp 17", n); end
    tests++; if (in_rdy !== 1'b1 || drop_pending !== 1'b0 || level !== 5'd0) begin
      fails++; $display("FAIL drain_end got in_rdy=%b dp=%b level=%0d exp 1/0/0", in_rdy, drop_pending, level); end
  endtask

  task automatic test_overflow_marker;
    fill_and_drop(3);
    drain_check(32'h8000_0003);
  endtask

  task automatic test_saturation;
    fill_and_drop(300);
    drain_check(32'h8000_00FF);
  endtask

  task automatic test_gap;
    int idx[$];
    logic [31:0] seen[$];
    g_out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      g_in_wr = 1'b1; g_in_data = 32'h3000_0000 | i;
      @(negedge clk);
    end
    g_in_wr = 1'b0; g_out_rdy = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (g_out_wr) begin idx.push_back(c); seen.push_back(g_out_data); end
    end
    tests++; if (idx.size() != 4) begin fails++; $display("FAIL gap_count got %0d exp 4", idx.size()); end
    for (int i = 1; i < 4 && i < idx.size(); i++) begin
      tests++; if (idx[i] - idx[i-1] != 4) begin fails++; $display("FAIL gap_spacing%0d got %0d exp 4", i, idx[i] - idx[i-1]); end
    end
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      tests++; if (seen[i] !== (32'h3000_0000 | i)) begin fails++; $display("FAIL gap_data%0d got %h exp %h", i, seen[i], 32'h3000_0000 | i); end
    end
  endtask

  task automatic test_flush;
    int strobes = 0;
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_wr = 1'b1; in_data = 32'h4000_0000 | i;
      @(negedge clk);
    end
    tests++; if (level !== 5'd5) begin fails++; $display("FAIL flush_pre_level got %0d exp 5", level); end
    flush = 1'b1; in_data = 32'h4000_00AA;
    @(negedge clk);
    flush = 1'b0; in_wr = 1'b0;
    tests++; if (level !== 5'd0 || out_wr !== 1'b0 || drop_pending !== 1'b0) begin
      fails++; $display("FAIL flush_state got level=%0d out_wr=%b dp=%b exp 0/0/0", level, out_wr, drop_pending); end
    tests++; if (out_data !== 32'h8000_00FF) begin fails++; $display("FAIL flush_out_data got %h exp 800000ff", out_data); end
    out_rdy = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_wr) strobes++;
    end
    tests++; if (strobes != 0 || level !== 5'd0) begin fails++; $display("FAIL flush_quiet got strobes=%0d level=%0d exp 0/0", strobes, level); end
  endtask

  task automatic test_async_reset;
    int strobes = 0;
    out_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_wr = 1'b1; in_data = 32'h5000_0000 | i;
      @(negedge clk);
    end
    in_wr = 1'b0; out_rdy = 1'b1;
    @(negedge clk);
    tests++; if (out_wr !== 1'b1 || out_data !== 32'h5000_0000) begin fails++; $display("FAIL ar_pre got %b/%h exp 1/50000000", out_wr, out_data); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out_wr !== 1'b0 || level !== 5'd0) begin fails++; $display("FAIL ar_async got out_wr=%b level=%0d exp 0/0", out_wr, level); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (level !== 5'd0 || in_rdy !== 1'b1 || out_data !== 32'd0) begin
      fails++; $display("FAIL ar_post got level=%0d in_rdy=%b out_data=%h exp 0/1/0", level, in_rdy, out_data); end
    repeat (5) begin
      @(negedge clk);
      if (out_wr) strobes++;
    end
    tests++; if (strobes != 0) begin fails++; $display("FAIL ar_lost got strobes=%0d exp 0", strobes); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow_marker();
    test_saturation();
    test_gap();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
